// File: rtl/sfp_pkg.sv
// Shared fixed-point width helpers for the
// raytracer datapath arithmetic stages.
package sfp_pkg;

  function automatic int mul_iw(input int iw_a,
                                input int iw_b);
    return iw_a + iw_b;
  endfunction

  function automatic int mul_qw(input int qw_a,
                                input int qw_b);
    return qw_a + qw_b;
  endfunction

  // integer growth of an n-term sum
  function automatic int add_grow(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sfp_pipe_reg.sv
// Generic elastic valid/ready register slice,
// full throughput, holds data while stalled.
module sfp_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // data only moves on an accepted handshake
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/sfp_dot3_pipe.sv
// Two-stage signed fixed-point 3-term dot
// product, full precision, elastic handshake.
module sfp_dot3_pipe
  import sfp_pkg::*;
#(
  parameter  int IW  = 4,
  parameter  int QW  = 12,
  localparam int WL  = IW + QW,
  localparam int OIW = mul_iw(IW, IW)
                     + add_grow(3),
  localparam int OQW = mul_qw(QW, QW),
  localparam int OWL = OIW + OQW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] a_x,
  input  logic [WL-1:0] a_y,
  input  logic [WL-1:0] a_z,
  input  logic [WL-1:0] b_x,
  input  logic [WL-1:0] b_y,
  input  logic [WL-1:0] b_z,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OWL-1:0] out_val
);

  localparam int PW = mul_iw(IW, IW)
                    + mul_qw(QW, QW);

  logic signed [PW-1:0] ax_e, ay_e, az_e;
  logic signed [PW-1:0] bx_e, by_e, bz_e;
  logic signed [PW-1:0] px_d, py_d, pz_d;
  logic signed [PW-1:0] px_q, py_q, pz_q;
  logic signed [OWL-1:0] sum_d;

  logic [3*PW-1:0] s1_in;
  logic [3*PW-1:0] s1_out;
  logic            s1_valid;
  logic            s1_ready;
  logic [OWL-1:0]  s2_out;

  assign ax_e = PW'($signed(a_x));
  assign ay_e = PW'($signed(a_y));
  assign az_e = PW'($signed(a_z));
  assign bx_e = PW'($signed(b_x));
  assign by_e = PW'($signed(b_y));
  assign bz_e = PW'($signed(b_z));

  assign px_d = ax_e * bx_e;
  assign py_d = ay_e * by_e;
  assign pz_d = az_e * bz_e;

  assign s1_in = {px_d, py_d, pz_d};

  sfp_pipe_reg #(
    .W(3*PW)
  ) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (s1_in),
    .out_valid(s1_valid),
    .out_ready(s1_ready),
    .out_data (s1_out)
  );

  assign {px_q, py_q, pz_q} = s1_out;

  // two bits of growth make the sum exact
  assign sum_d = OWL'(px_q)
               + OWL'(py_q)
               + OWL'(pz_q);

  sfp_pipe_reg #(
    .W(OWL)
  ) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s1_valid),
    .in_ready (s1_ready),
    .in_data  (sum_d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (s2_out)
  );

  assign out_val = s2_out;

endmodule

// File: tb/tb_sfp_dot3_pipe.sv
// Directed + randomized-stall bench with a
// queue scoreboard for sfp_dot3_pipe.
module tb_sfp_dot3_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_x, a_y, a_z;
  logic [15:0] b_x, b_y, b_z;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] out_val;

  int total = 0;
  int bad   = 0;
  int nin   = 0;
  int nout  = 0;

  longint      q[$];
  logic        hold_v = 1'b0;
  logic [33:0] hold_d;

  always #5 clk = ~clk;

  sfp_dot3_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_x      (a_x),
    .a_y      (a_y),
    .a_z      (a_z),
    .b_x      (b_x),
    .b_y      (b_y),
    .b_z      (b_z),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_val  (out_val)
  );

  function automatic longint sx(
    input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  // reference: real-valued dot product scaled
  // by 2^24, as plain integer arithmetic
  function automatic longint dot3();
    return sx(a_x) * sx(b_x)
         + sx(a_y) * sx(b_y)
         + sx(a_z) * sx(b_z);
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic put(input logic [95:0] v);
    {a_x, a_y, a_z, b_x, b_y, b_z} = v;
  endtask

  function automatic logic [95:0] rnd();
    return {16'($urandom()), 16'($urandom()),
            16'($urandom()), 16'($urandom()),
            16'($urandom()), 16'($urandom())};
  endfunction

  // scoreboard / stall-hold compare process
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        total++;
        if (!out_valid || out_val !== hold_d) begin
          bad++;
          $display("FAIL hold: got v=%b %0h want %0h",
                   out_valid, out_val, hold_d);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        nout++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL extra_out: got %0h want none",
                   out_val);
        end else begin
          longint e;
          longint a;
          e = q.pop_front();
          a = longint'($signed(out_val));
          if (a != e) begin
            bad++;
            $display("FAIL result: got %0d want %0d",
                     a, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(dot3());
        nin++;
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_val;
    end
  end

  task automatic one(input string nm,
                     input logic [95:0] v,
                     input logic [33:0] exp);
    @(posedge clk); #1;
    put(v);
    in_valid = 1'b1;
    @(negedge clk);
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_early"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_valid"}, 64'(out_valid), 64'd1);
    chk({nm, "_val"}, 64'(out_val), 64'(exp));
  endtask

  localparam logic [95:0] VBASIC =
    {16'h1000, 16'h2000, 16'hF800,
     16'h0800, 16'h0400, 16'h4000};
  localparam logic [95:0] VEXT =
    {6{16'h8000}};

  logic [95:0] bp[4];
  int k;
  logic acc;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    put('0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_val", 64'(out_val), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    one("basic", VBASIC, 34'h3_FF00_0000);
    one("extreme", VEXT, 34'h0_C000_0000);

    // back-to-back throughput
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      in_valid = (i < 10);
      if (i < 10) put(rnd());
      @(negedge clk);
      if (i < 10)
        chk("tput_in_ready", 64'(in_ready), 64'd1);
      chk("tput_out_valid", 64'(out_valid),
          64'((i >= 2) && (i <= 11)));
    end

    // backpressure: capacity of two
    for (int i = 0; i < 4; i++) bp[i] = rnd();
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      put(bp[k]);
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready),
          64'(c < 2));
      if (in_valid && in_ready) k++;
    end
    chk("bp_accepted", 64'(k), 64'd2);
    for (int c = 0; c < 20 && k < 4; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      put(bp[k]);
      @(negedge clk);
      if (in_valid && in_ready) k++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bp_drain", 64'(q.size()), 64'd0);

    // random stalls
    k = 0;
    acc = 1'b0;
    for (int c = 0; c < 20000 && k < 1000; c++) begin
      @(posedge clk); #1;
      if (acc || !in_valid) begin
        in_valid = 1'($urandom_range(0, 1));
        put(rnd());
      end
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) k++;
    end
    chk("rand_sent", 64'(k), 64'd1000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && q.size() != 0; c++)
      @(negedge clk);
    chk("rand_drain", 64'(q.size()), 64'd0);
    chk("rand_count", 64'(nout), 64'(nin));

    // reset with both stages full
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      put(rnd());
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_full", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_out_val", 64'(out_val), 64'd0);
    chk("mid_in_ready", 64'(in_ready), 64'd1);
    one("post_rst", VBASIC, 34'h3_FF00_0000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("final_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/sfp_dot3_pipe.md
Name: sfp_dot3_pipe

Overview:
- Pipelined signed fixed-point 3-component dot product: out = ax*bx + ay*by + az*bz.
- Used for ray/normal and ray/vector products in the raytracer datapath.
- Output is full precision with no rounding or clipping. It feeds directly into the downstream sfp_resize stage, which narrows it to the working format.
- Elastic valid/ready on both sides; 2-cycle latency; one result per cycle at full throughput.

Parameters:
- IW, 4, integer bits of each input operand, sign bit included.
- QW, 12, fractional bits of each input operand.
- WL, IW+QW (derived, not overridable), input word length.
- OIW, 2*IW+2 (derived), output integer bits.
- OQW, 2*QW (derived), output fractional bits.
- OWL, OIW+OQW (derived), output word length.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand vector valid
- in_ready  output  1  stage can accept operands this cycle
- a_x, a_y, a_z  input  WL each  signed operand A components, format IW.QW
- b_x, b_y, b_z  input  WL each  signed operand B components, format IW.QW
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result this cycle
- out_val  output  OWL  signed dot product, format OIW.OQW

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (rst).
- Reset: s1_valid=0, s2_valid=0, out_valid=0, all product and sum registers = 0, out_val=0.
  - A reset mid-transaction discards in-flight data with no output.
  - in_ready=1 in the first cycle after reset is released.
- Stage 1 (S1) registers three products p_k = a_k*b_k.
  - Full signed multiply; width 2*WL; format 2IW.2QW.
- Stage 2 (S2) registers sum = sext(p_x) + sext(p_y) + sext(p_z).
  - All terms sign-extended to OWL; no overflow is possible.
  - Worst case is 3 * (-2^(IW-1))^2, e.g. 192 for IW=4, which lies inside the OIW range of ±2^(OIW-1).
- out_val = S2 sum register; out_valid = s2_valid.
- Handshake, with each stage ready computed as:
  - s2_ready = !s2_valid || out_ready
  - s1_ready = !s1_valid || s2_ready
  - in_ready = s1_ready (combinational path from out_ready is permitted)
- Transfers:
  - Input accepted when in_valid && in_ready; S1 loads products, s1_valid <= 1.
  - If s1_ready && !in_valid, then s1_valid <= 0.
  - S2 loads when s1_valid && s2_ready; s2_valid <= 1.
  - If s2_ready && !s1_valid, then s2_valid <= 0.
- Latency: operands accepted in cycle N appear with out_valid=1 in cycle N+2 when out_ready is held high.
- Throughput: 1 result per cycle with out_ready=1 continuously.
- Stall: out_valid && !out_ready holds out_val stable and unchanged until accepted (AXI-style). S1 likewise holds while S2 is full and stalled.
- Capacity: 2 vectors in flight. With out_ready=0 the block accepts exactly 2 vectors, then deasserts in_ready.
- Simultaneous out handshake and S1 advance in the same cycle: S2 takes the new sum; no bubble is inserted.
- Operands are sampled only on an accepted handshake. Inputs when in_valid=0 are don't-care and must not affect state.
- No X propagation from un-accepted inputs to out_val.

Decomposition:
- Shared package sfp_pkg:
  - width helper functions mul_iw(iw_a, iw_b) = iw_a+iw_b and mul_qw = qw_a+qw_b
  - add_grow(n) = $clog2(n) bits of integer growth for an n-term sum
- Sub-module sfp_pipe_reg: generic elastic register with parameter W.
  - Ports: clk, rst, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
  - Instantiated twice, for S1 (3*2*WL bits) and S2 (OWL bits).
  - The multiply and add logic sits combinationally between the two instances.

Test Plan (IW=4, QW=12, so OWL=34, OQW=24):
- Basic value: a=(1.0, 2.0, -0.5), b=(0.5, 0.25, 4.0), out_ready=1.
  - -> cycle+2: out_valid=1, out_val = -1.0 = -16777216 (34'h3_FF00_0000).
- Extreme value: all components = -8.0 (16'h8000).
  - -> out_val = 192.0 = 3221225472 (34'h0_C000_0000), with no wrap.
- Throughput: 10 back-to-back random vectors, out_ready=1.
  - -> 10 consecutive out_valid cycles starting at +2, with in_ready=1 throughout.
  - Results match the reference model bit-exact.
- Backpressure: out_ready=0, in_valid=1 for 4 cycles.
  - -> exactly 2 accepted, in_ready=0 from the third cycle, out_val held stable.
  - Then out_ready=1 -> the 2 results drain in order, followed by the remaining inputs.
- Random stall: randomized in_valid and out_ready (50%) over 1000 vectors.
  - -> no loss, duplication or reordering against a scoreboard.
- Reset mid-flight: assert rst for 1 cycle while both stages are valid.
  - -> next cycle out_valid=0, out_val=0, in_ready=1; the next accepted vector returns correctly at +2.
